// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage M-extension unit: aluop codes, FSM states,
// bus widths and small operand-decode helpers.
package ex_muldiv_pkg;

    localparam int ALU_OP_W   = 8;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [ALU_OP_W-1:0] OP_MUL    = 8'hA0;
    localparam logic [ALU_OP_W-1:0] OP_MULH   = 8'hA1;
    localparam logic [ALU_OP_W-1:0] OP_MULHSU = 8'hA2;
    localparam logic [ALU_OP_W-1:0] OP_MULHU  = 8'hA3;
    localparam logic [ALU_OP_W-1:0] OP_DIV    = 8'hA4;
    localparam logic [ALU_OP_W-1:0] OP_DIVU   = 8'hA5;
    localparam logic [ALU_OP_W-1:0] OP_REM    = 8'hA6;
    localparam logic [ALU_OP_W-1:0] OP_REMU   = 8'hA7;

    localparam logic [DATA_W-1:0]     ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_mop(input logic [ALU_OP_W-1:0] op);
        return (op == OP_MUL)  || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU) ||
               (op == OP_DIV)  || (op == OP_DIVU) || (op == OP_REM)    || (op == OP_REMU);
    endfunction

    function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_rem_op(input logic [ALU_OP_W-1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic rs1_signed(input logic [ALU_OP_W-1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic rs2_signed(input logic [ALU_OP_W-1:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Restoring divider datapath: load unsigned magnitudes, then one quotient bit per step.
module ex_muldiv_div_iter
    import ex_muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_quot,
    output logic [DATA_W-1:0] o_rem
);

    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_dvsr;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_diff;
    logic              w_ge;

    // Partial remainder stays below the divisor, so the shifted value fits in 33 bits
    // and a successful subtraction always fits back into 32.
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvsr};
    assign w_ge    = ~w_diff[DATA_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvsr <= '0;
        end else if (i_load) begin
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_dvsr <= i_divisor;
        end else if (i_step) begin
            r_quo <= {r_quo[DATA_W-2:0], w_ge};
            r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
        end
    end

    assign o_quot = r_quo;
    assign o_rem  = r_rem;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle multiply/divide unit for the RISC-V M extension.
// state | meaning
// IDLE  | waiting for an M-op; accepts and latches operands
// MUL   | 32 shift-add iterations on the 64-bit accumulator
// DIV   | 32 restoring-division iterations in the divider sub-module
// DONE  | sign fixup, result driven with valid_o for one cycle
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU_OP_W-1:0]   aluop_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic                  stallreq_o,
    output logic                  valid_o,
    output logic [DATA_W-1:0]     result_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o
);

    muldiv_state_e r_state;
    muldiv_state_e w_state_nxt;

    logic [ALU_OP_W-1:0]   r_op;
    logic [REG_ADDR_W-1:0] r_wd;
    logic                  r_wreg;
    logic                  r_is_div;
    logic                  r_neg_res;
    logic                  r_neg_rem;
    logic                  r_bypass;
    logic [DATA_W-1:0]     r_byp_res;
    logic [4:0]            r_cnt;
    logic [2*DATA_W-1:0]   r_acc;
    logic [2*DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]     r_mplier;

    logic                  w_mop;
    logic                  w_accept;
    logic                  w_neg1;
    logic                  w_neg2;
    logic [DATA_W-1:0]     w_mag1;
    logic [DATA_W-1:0]     w_mag2;
    logic                  w_div_zero;
    logic                  w_div_ovf;
    logic                  w_bypass;
    logic [DATA_W-1:0]     w_byp_res;
    logic                  w_last_iter;
    logic                  w_div_step;
    logic [DATA_W-1:0]     w_quot;
    logic [DATA_W-1:0]     w_rem;
    logic [2*DATA_W-1:0]   w_prod;
    logic [DATA_W-1:0]     w_mul_res;
    logic [DATA_W-1:0]     w_div_res;
    logic [DATA_W-1:0]     w_result;
    logic                  w_valid;

    assign w_mop    = is_mop(aluop_i);
    assign w_accept = (r_state == ST_IDLE) && w_mop && !flush_i;

    assign w_neg1 = rs1_signed(aluop_i) && reg1_i[DATA_W-1];
    assign w_neg2 = rs2_signed(aluop_i) && reg2_i[DATA_W-1];
    assign w_mag1 = w_neg1 ? -reg1_i : reg1_i;
    assign w_mag2 = w_neg2 ? -reg2_i : reg2_i;

    // Divide-by-zero and signed overflow have architecturally fixed results, so they skip iteration.
    assign w_div_zero = (reg2_i == ZERO_WORD);
    assign w_div_ovf  = ((aluop_i == OP_DIV) || (aluop_i == OP_REM)) &&
                        (reg1_i == 32'h8000_0000) && (reg2_i == 32'hFFFF_FFFF);
    assign w_bypass   = is_div_op(aluop_i) && (w_div_zero || w_div_ovf);
    assign w_byp_res  = w_div_zero ? (is_rem_op(aluop_i) ? reg1_i : 32'hFFFF_FFFF)
                                   : (is_rem_op(aluop_i) ? ZERO_WORD : 32'h8000_0000);

    assign w_last_iter = (r_cnt == 5'd31);
    assign w_div_step  = (r_state == ST_DIV) && !flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mop) begin
                        if (w_bypass)                w_state_nxt = ST_DONE;
                        else if (is_div_op(aluop_i)) w_state_nxt = ST_DIV;
                        else                         w_state_nxt = ST_MUL;
                    end
                end
                ST_MUL:  if (w_last_iter) w_state_nxt = ST_DONE;
                ST_DIV:  if (w_last_iter) w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op      <= '0;
            r_wd      <= NOP_REG_ADDR;
            r_wreg    <= 1'b0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_bypass  <= 1'b0;
            r_byp_res <= ZERO_WORD;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
        end else if (w_accept) begin
            r_op      <= aluop_i;
            r_wd      <= wd_i;
            r_wreg    <= wreg_i;
            r_is_div  <= is_div_op(aluop_i);
            r_neg_res <= w_neg1 ^ w_neg2;
            r_neg_rem <= w_neg1;
            r_bypass  <= w_bypass;
            r_byp_res <= w_byp_res;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= {ZERO_WORD, w_mag1};
            r_mplier  <= w_mag2;
        end else if (!flush_i && (r_state == ST_MUL)) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= {r_mcand[2*DATA_W-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[DATA_W-1:1]};
            r_cnt    <= r_cnt + 5'd1;
        end else if (w_div_step) begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

    ex_muldiv_div_iter u_div_iter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_step     (w_div_step),
        .i_dividend (w_mag1),
        .i_divisor  (w_mag2),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    // Remainder takes the dividend's sign; quotient and product take the XOR of operand signs.
    assign w_prod    = r_neg_res ? -r_acc : r_acc;
    assign w_mul_res = (r_op == OP_MUL) ? w_prod[DATA_W-1:0] : w_prod[2*DATA_W-1:DATA_W];
    assign w_div_res = r_bypass        ? r_byp_res :
                       is_rem_op(r_op) ? (r_neg_rem ? -w_rem  : w_rem)
                                       : (r_neg_res ? -w_quot : w_quot);
    assign w_result  = r_is_div ? w_div_res : w_mul_res;

    assign w_valid    = (r_state == ST_DONE) && !flush_i;
    assign valid_o    = w_valid;
    assign result_o   = w_valid ? w_result : ZERO_WORD;
    assign wd_o       = w_valid ? r_wd : NOP_REG_ADDR;
    assign wreg_o     = w_valid && r_wreg;
    assign stallreq_o = !flush_i && (((r_state == ST_IDLE) && w_mop) ||
                                     (r_state == ST_MUL) || (r_state == ST_DIV));

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state on its rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: aluop_i  in  AluOpBus  operation from ID/EX register; M-extension codes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-004 SHALL have ports: reg1_i  in  32  rs1 operand; reg2_i  in  32  rs2 operand.
REQ-005 SHALL have ports: wd_i  in  RegAddrBus  destination register; wreg_i  in  1  write enable.
REQ-006 SHALL have ports: flush_i  in  1  EX flush (branch mispredict).
REQ-007 SHALL have ports: stallreq_o  out  1  pipeline stall request to controller.
REQ-008 SHALL have ports: valid_o  out  1  result valid (one cycle).
REQ-009 SHALL have ports: result_o  out  32  rd write data; wd_o  out  RegAddrBus; wreg_o  out  1.

Function
REQ-010 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-011 IDLE: if aluop_i is M-op and flush_i=0, SHALL latch operands, op, wd_i, wreg_i, clear counter, go MUL (MUL*) or DIV (DIV*/REM*); else stay IDLE.
REQ-012 Signed ops SHALL latch magnitudes plus result-sign flag; MULHSU treats reg1 signed, reg2 unsigned; U-ops unsigned.
REQ-013 MUL: radix-2 shift-add over 64-bit accumulator, one bit per cycle, exactly 32 cycles, then DONE.
REQ-014 DIV: restoring division, one quotient bit per cycle, exactly 32 cycles, then DONE.
REQ-015 Divisor zero SHALL bypass iteration (IDLE->DONE): quotient 0xFFFFFFFF, remainder = reg1_i.
REQ-016 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL bypass iteration: quotient 0x80000000, remainder 0.
REQ-017 DONE: SHALL apply sign fixup (remainder sign = dividend sign), select low word (MUL) or high word (MULH*), drive result_o, valid_o=1 for exactly one cycle, then IDLE.
REQ-018 stallreq_o SHALL be combinational: 1 when (IDLE and M-op and not flush_i) or state in {MUL, DIV}; 0 in DONE.
REQ-019 Latency: accept cycle + 32 iterations + DONE = result in cycle 34 from accept; bypass cases: result in cycle 2.
REQ-020 While stalled, changes on aluop_i/reg1_i/reg2_i SHALL be ignored; operands come only from latched copies.
REQ-021 The instruction still present at inputs in DONE SHALL NOT restart (DONE always returns to IDLE).
REQ-022 flush_i=1 in any state SHALL force IDLE next cycle, valid_o=0, stallreq_o=0 same cycle, no write.
REQ-023 Non-M aluop_i SHALL leave outputs at valid_o=0, wreg_o=0, result_o=0.
REQ-024 wreg_o SHALL equal latched wreg only while valid_o=1; otherwise 0.

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE, counter 0, result_o=0, wd_o=NOPRegAddr, wreg_o=0, valid_o=0.
REQ-026 Reset mid-operation SHALL abandon the operation with no write; first accept after release begins fresh.

Structure
REQ-027 M-extension aluop codes, FSM state encodings and ZeroWord/NOPRegAddr SHALL live in shared defines.v.
REQ-028 Divider datapath SHALL be sub-module div_iter (operand load, per-cycle step, quotient/remainder out); multiplier stays inline.

Verification
REQ-029 MUL 7 x -3 -> stallreq 33 cycles, valid in cycle 34, result 0xFFFFFFEB, wreg_o=1.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-031 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14.
REQ-032 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, each valid in cycle 2.
REQ-033 flush_i pulse at iteration 10 -> IDLE next cycle, no valid_o, stallreq 0; following MUL 3x4 -> 12.
REQ-034 rst low at iteration 20 -> outputs reset immediately; after release DIVU 9/3 -> 3.
